// File: rtl/hazard_unit.sv
// hazard_unit: RV32 pipeline hazard control with registered E/M/W tag mirror and optional stall/flush counters
module hazard_unit #(
  parameter int REG_ADDR_W = 6,
  parameter logic [1:0] LOAD_SRC = 2'b01,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] RS1D,
  input  logic [REG_ADDR_W-1:0] RS2D,
  input  logic [REG_ADDR_W-1:0] RDD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    StallCount,
  output logic [CNT_W-1:0]      FlushCount
`endif
);
  logic                  rw_e, ld_e, rw_m, rw_w, lw_stall;
  logic [REG_ADDR_W-1:0] rd_e, rs1_e, rs2_e, rd_m, rd_w;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {rw_e, ld_e, rd_e, rs1_e, rs2_e} <= '0;
      {rw_m, rd_m, rw_w, rd_w} <= '0;
    end else begin
      {rw_e, ld_e, rd_e, rs1_e, rs2_e} <= FlushE ? '0 :
        {RegWriteD, ResultSrcD == LOAD_SRC, RDD, RS1D, RS2D};
      {rw_m, rd_m} <= {rw_e, rd_e};
      {rw_w, rd_w} <= {rw_m, rd_m};
    end
  end
  always_comb begin
    lw_stall  = ld_e && rw_e && rd_e != '0 && (rd_e == RS1D || rd_e == RS2D);
    FlushD    = rst_n && PCSrcE;
    FlushE    = rst_n && (PCSrcE || lw_stall);
    StallF    = rst_n && lw_stall && !PCSrcE;
    StallD    = StallF;
    ForwardAE = !rst_n ? 2'b00 :
                (rw_m && rd_m != '0 && rd_m == rs1_e) ? 2'b10 :
                (rw_w && rd_w != '0 && rd_w == rs1_e) ? 2'b01 : 2'b00;
    ForwardBE = !rst_n ? 2'b00 :
                (rw_m && rd_m != '0 && rd_m == rs2_e) ? 2'b10 :
                (rw_w && rd_w != '0 && rd_w == rs2_e) ? 2'b01 : 2'b00;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD) stall_cnt <= stall_cnt + CNT_W'(1);
      if (PCSrcE) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign StallCount = rst_n ? stall_cnt : '0;
  assign FlushCount = rst_n ? flush_cnt : '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector table, hand sequences and randomized model check for hazard_unit
module tb_hazard_unit;
  logic       clk = 0, rst_n = 0, rw = 0, pc = 0;
  logic [5:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [1:0] src = 0;
  logic       sf, sd, fd, fe;
  logic [1:0] fa, fb;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] sc, fc;
  logic [3:0] m_sc, m_fc;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .RS1D(rs1), .RS2D(rs2), .RDD(rd),
    .RegWriteD(rw), .ResultSrcD(src), .PCSrcE(pc),
    .StallF(sf), .StallD(sd), .FlushD(fd), .FlushE(fe),
    .ForwardAE(fa), .ForwardBE(fb)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(sc), .FlushCount(fc)
`endif
  );

  typedef struct {
    logic [5:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] src;
    logic       pc;
    logic [3:0] st;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    logic       rw, ld;
    logic [5:0] rd, rs1, rs2;
  } ent_t;

  vec_t vt[16];
  ent_t pipe[3];

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", n, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] d, input logic w, input logic [1:0] s, input logic p);
    rst_n = r; rs1 = a; rs2 = b; rd = d; rw = w; src = s; pc = p;
  endtask

  task automatic expect_out(input string n, input logic [3:0] st, input logic [1:0] ea, input logic [1:0] eb);
    @(negedge clk);
    chk({n, ".stall_flush"}, {sf, sd, fd, fe}, st);
    chk({n, ".fwdA"}, {2'b00, fa}, {2'b00, ea});
    chk({n, ".fwdB"}, {2'b00, fb}, {2'b00, eb});
    @(posedge clk); #1;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [5:0] rs);
    for (int k = 1; k < 3; k++)
      if (pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs) return k == 1 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  initial begin
    vt[0]  = '{0, 0, 0,  0, 0, 0, 4'b0000, 0, 0};
    vt[1]  = '{1, 2, 5,  1, 0, 0, 4'b0000, 0, 0};
    vt[2]  = '{5, 3, 6,  1, 0, 0, 4'b0000, 0, 0};
    vt[3]  = '{5, 0, 9,  1, 0, 0, 4'b0000, 2, 0};
    vt[4]  = '{0, 0, 7,  1, 1, 0, 4'b0000, 1, 0};
    vt[5]  = '{1, 7, 10, 1, 0, 0, 4'b1101, 0, 0};
    vt[6]  = '{1, 7, 10, 1, 0, 0, 4'b0000, 0, 0};
    vt[7]  = '{0, 0, 0,  0, 0, 0, 4'b0000, 0, 1};
    vt[8]  = '{0, 0, 7,  1, 1, 0, 4'b0000, 0, 0};
    vt[9]  = '{7, 0, 11, 1, 0, 1, 4'b0011, 0, 0};
    vt[10] = '{0, 0, 0,  1, 0, 0, 4'b0000, 0, 0};
    vt[11] = '{0, 0, 3,  1, 0, 0, 4'b0000, 0, 0};
    vt[12] = '{0, 0, 3,  1, 0, 0, 4'b0000, 0, 0};
    vt[13] = '{3, 3, 0,  0, 0, 0, 4'b0000, 0, 0};
    vt[14] = '{0, 0, 0,  0, 0, 0, 4'b0000, 2, 2};
    vt[15] = '{0, 0, 0,  0, 0, 0, 4'b0000, 0, 0};

    @(posedge clk); #1;
    drive(0, 7, 7, 7, 1, 1, 1);
    expect_out("reset0", 4'b0000, 0, 0);
    expect_out("reset1", 4'b0000, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].rw, vt[i].src, vt[i].pc);
      expect_out($sformatf("vec%0d", i), vt[i].st, vt[i].fa, vt[i].fb);
    end

    drive(1, 0, 0, 7, 1, 1, 0);
    expect_out("midrst_lw", 4'b0000, 0, 0);
    drive(1, 7, 0, 4, 1, 0, 0);
    expect_out("midrst_stall", 4'b1101, 0, 0);
    drive(0, 7, 0, 4, 1, 0, 0);
    expect_out("midrst_low", 4'b0000, 0, 0);
    drive(1, 7, 0, 4, 1, 0, 0);
    expect_out("midrst_after", 4'b0000, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic       r, lw, xst;
      logic [1:0] xa, xb;
      ent_t       e;
      r = (i == 0) ? 1'b0 : ($urandom_range(31) != 0);
      drive(r, 6'($urandom_range(7)), 6'($urandom_range(7)), 6'($urandom_range(7)),
            1'($urandom_range(1)), 2'($urandom_range(3)), $urandom_range(7) == 0);
      e   = pipe[0];
      lw  = e.ld && e.rw && e.rd != 0 && (e.rd == rs1 || e.rd == rs2);
      xst = r && lw && !pc;
      xa  = r ? ref_fwd(e.rs1) : 2'b00;
      xb  = r ? ref_fwd(e.rs2) : 2'b00;
      @(negedge clk);
      chk("rand.stall_flush", {sf, sd, fd, fe}, {xst, xst, r && pc, r && (pc || lw)});
      chk("rand.fwdA", {2'b00, fa}, {2'b00, xa});
      chk("rand.fwdB", {2'b00, fb}, {2'b00, xb});
`ifdef HAZARD_PERF_CNT_EN
      if (i > 0) begin
        chk("rand.StallCount", sc, r ? m_sc : 4'd0);
        chk("rand.FlushCount", fc, r ? m_fc : 4'd0);
      end
`endif
      @(posedge clk);
      if (!r) begin
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0};
`ifdef HAZARD_PERF_CNT_EN
        m_sc = 0; m_fc = 0;
`endif
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (pc || lw) ? '{0, 0, 0, 0, 0} : '{rw, src == 2'b01, rd, rs1, rs2};
`ifdef HAZARD_PERF_CNT_EN
        m_sc = m_sc + 4'(xst);
        m_fc = m_fc + 4'(pc);
`endif
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
